// File: rtl/delay_chain_prober.sv
// delay_chain_prober
//
// Measures the propagation delay of an on-chip delay chain in clk cycles.
// Each launch toggles the chain input and counts cycles until the far end
// is seen at the same level through a two-flop synchronizer. Over
// 2^LOG_REPS launches the polarity alternates. The per-launch counts are
// summed and reported as one result.
//
// Ports:
//   clk         single rising-edge clock
//   rst         synchronous active-high reset
//   start       measurement request, only looked at while idle
//   chain_din   registered drive into the chain launch end
//   chain_dout  chain far end, asynchronous to clk
//   busy        high whenever a measurement is in progress
//   done        one-cycle pulse at the end of each measurement
//   timeout     sticky flag: the last measurement hit the per-launch limit
//   result      summed cycle count of the last measurement (all ones on timeout)

module delay_chain_prober #(
  parameter int MAX_CYC    = 255,
  parameter int SETTLE_CYC = 4,
  parameter int LOG_REPS   = 3,
  localparam int CW = $clog2(MAX_CYC + 1),
  localparam int RW = CW + LOG_REPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          chain_din,
  input  logic          chain_dout,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [RW-1:0] result
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int PW = (LOG_REPS > 0) ? LOG_REPS : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(MAX_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] REP_LAST    = PW'((1 << LOG_REPS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          sync1;
  logic          dout_s;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] rep;
  logic [RW-1:0] acc;

  logic          clear;
  logic          launch;
  logic          arrive;
  logic          expire;

  // Next-state decode plus the single-cycle strobes that steer the datapath.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    launch     = 1'b0;
    arrive     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          launch     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // Arrival has priority over the timeout on the very last count.
        if (dout_s == chain_din) begin
          arrive     = 1'b1;
          next_state = (rep == REP_LAST) ? DONE : SETTLE;
        end else if (cnt == CNT_LAST) begin
          expire     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Status outputs are pure state decodes so busy and done drop together.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // State register, synchronizer and measurement datapath.
  // result is loaded on the edge that enters DONE so it is already valid
  // while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      dout_s     <= 1'b0;
      chain_din  <= 1'b0;
      settle_cnt <= '0;
      cnt        <= '0;
      rep        <= '0;
      acc        <= '0;
      timeout    <= 1'b0;
      result     <= '0;
    end else begin
      state  <= next_state;
      sync1  <= chain_dout;
      dout_s <= sync1;

      if (clear) begin
        acc        <= '0;
        rep        <= '0;
        timeout    <= 1'b0;
        settle_cnt <= '0;
      end

      if (state == SETTLE) begin
        if (launch) begin
          chain_din  <= ~chain_din;
          cnt        <= '0;
          settle_cnt <= '0;
        end else begin
          settle_cnt <= settle_cnt + SW'(1);
        end
      end

      if (arrive) begin
        acc <= acc + RW'(cnt);
        rep <= rep + PW'(1);
        if (rep == REP_LAST) begin
          result <= acc + RW'(cnt);
        end
      end else if (expire) begin
        timeout <= 1'b1;
        result  <= '1;
      end else if (state == WAIT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_chain_prober.sv
// tb_delay_chain_prober
//
// Exercises two prober instances: dut0 with default parameters and dut1
// with a short timeout, short settle and two launches per measurement.
// Each chain is emulated by a behavioural model with independent rise and
// fall delays in whole cycles, or stuck at a constant level.

module tb_delay_chain_prober;

  localparam int MAXC0 = 255;
  localparam int SET0  = 4;
  localparam int LR0   = 3;
  localparam int RW0   = $clog2(MAXC0 + 1) + LR0;
  localparam int MAXC1 = 16;
  localparam int SET1  = 2;
  localparam int LR1   = 1;
  localparam int RW1   = $clog2(MAXC1 + 1) + LR1;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic din0, din1, dout0, dout1;
  logic busy0, busy1, done0, done1, tmo0, tmo1;
  logic [RW0-1:0] res0;
  logic [RW1-1:0] res1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  delay_chain_prober #(.MAX_CYC(MAXC0), .SETTLE_CYC(SET0), .LOG_REPS(LR0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .chain_din(din0), .chain_dout(dout0),
    .busy(busy0), .done(done0), .timeout(tmo0), .result(res0)
  );

  delay_chain_prober #(.MAX_CYC(MAXC1), .SETTLE_CYC(SET1), .LOG_REPS(LR1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .chain_din(din1), .chain_dout(dout1),
    .busy(busy1), .done(done1), .timeout(tmo1), .result(res1)
  );

  // Chain models. mode 0: rise/fall delays in cycles, 1: stuck 0, 2: stuck 1.
  logic [15:0] hist0 = '0;
  logic [15:0] hist1 = '0;
  int mode0 = 0, rise0 = 0, fall0 = 0;
  int mode1 = 0, rise1 = 0, fall1 = 0;

  always @(posedge clk) begin
    hist0 <= {hist0[14:0], din0};
    hist1 <= {hist1[14:0], din1};
  end

  function automatic logic tap(input logic [15:0] h, input logic d, input int x);
    return (x == 0) ? d : h[x-1];
  endfunction

  // The slower edge is the one that needs both taps to agree.
  function automatic logic chain_out(input logic [15:0] h, input logic d,
                                     input int mode, input int r, input int f);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    if (r >= f) return tap(h, d, r) & tap(h, d, f);
    return tap(h, d, r) | tap(h, d, f);
  endfunction

  assign dout0 = chain_out(hist0, din0, mode0, rise0, fall0);
  assign dout1 = chain_out(hist1, din1, mode1, rise1, fall1);

  // Expected chain input level, tracked purely from launch counts.
  logic din_model0, din_model1;

  function automatic logic obs_busy(input int sel);
    return sel ? busy1 : busy0;
  endfunction
  function automatic logic obs_done(input int sel);
    return sel ? done1 : done0;
  endfunction
  function automatic logic obs_tmo(input int sel);
    return sel ? tmo1 : tmo0;
  endfunction
  function automatic logic obs_din(input int sel);
    return sel ? din1 : din0;
  endfunction
  function automatic logic [63:0] obs_res(input int sel);
    return sel ? 64'(res1) : 64'(res0);
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start1 = v;
    else start0 = v;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Lap-level reference: each launch flips the level; a modelled chain
  // arrives after 2 sync cycles plus the edge delay, a stuck chain arrives
  // at once when already at the target level and otherwise times out.
  task automatic ref_model(input int sel, input int mode, input int r, input int f,
                           inout logic din, output logic [63:0] res,
                           output logic tmo, output int busy);
    int lr, settle, maxc, rw, cnt;
    longint acc;
    logic target;
    lr     = sel ? LR1 : LR0;
    settle = sel ? SET1 : SET0;
    maxc   = sel ? MAXC1 : MAXC0;
    rw     = sel ? RW1 : RW0;
    acc  = 0;
    tmo  = 1'b0;
    busy = 0;
    for (int lap = 0; lap < (1 << lr); lap++) begin
      target = ~din;
      din    = target;
      busy  += settle;
      if (mode == 0) begin
        cnt = 2 + (target ? r : f);
      end else if ((mode == 1 && target == 1'b0) || (mode == 2 && target == 1'b1)) begin
        cnt = 0;
      end else begin
        tmo   = 1'b1;
        busy += maxc;
        break;
      end
      acc  += cnt;
      busy += cnt + 1;
    end
    busy += 1;
    res = tmo ? ((64'd1 << rw) - 64'd1) : 64'(acc);
  endtask

  // Runs one full measurement. exp_res/exp_tmo < 0 means take them from
  // the reference model; pulse_at > 0 pulses start during that busy cycle.
  task automatic applyStimulus(input int sel, input int mode, input int r, input int f,
                               input int pulse_at, input longint exp_res,
                               input int exp_tmo, input string name);
    logic [63:0] m_res;
    logic m_tmo, din_m, got;
    int m_busy, busy_cnt;
    if (sel != 0) begin
      mode1 = mode; rise1 = r; fall1 = f;
      din_m = din_model1;
    end else begin
      mode0 = mode; rise0 = r; fall0 = f;
      din_m = din_model0;
    end
    ref_model(sel, mode, r, f, din_m, m_res, m_tmo, m_busy);
    if (exp_res >= 0) m_res = 64'(exp_res);
    if (exp_tmo >= 0) m_tmo = exp_tmo[0];
    repeat (20) @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (obs_busy(sel)) busy_cnt++;
      set_start(sel, (i + 1 == pulse_at));
      if (obs_done(sel)) got = 1'b1;
    end
    set_start(sel, 1'b0);
    checkOutput({name, " done_seen"}, 64'(got), 64'd1);
    checkOutput({name, " result"}, obs_res(sel), m_res);
    checkOutput({name, " timeout"}, 64'(obs_tmo(sel)), 64'(m_tmo));
    checkOutput({name, " busy_cycles"}, 64'(busy_cnt), 64'(m_busy));
    @(negedge clk);
    checkOutput({name, " done_after"}, 64'(obs_done(sel)), 64'd0);
    checkOutput({name, " busy_after"}, 64'(obs_busy(sel)), 64'd0);
    checkOutput({name, " chain_din"}, 64'(obs_din(sel)), 64'(din_m));
    checkOutput({name, " result_hold"}, obs_res(sel), m_res);
    if (sel != 0) din_model1 = din_m;
    else din_model0 = din_m;
  endtask

  typedef struct {
    int     sel;
    int     mode;
    int     r;
    int     f;
    int     pulse_at;
    longint exp_res;
    int     exp_tmo;
    string  name;
  } vec_t;

  vec_t vecs[9];

  // Safety net in case some wait is ever left unbounded.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic got;
    int busy_cnt, done_cnt;

    vecs[0] = '{0, 0, 0, 0, 0, 16, 0, "loopback"};
    vecs[1] = '{0, 0, 5, 5, 0, 56, 0, "shift5"};
    vecs[2] = '{0, 0, 3, 1, 0, 32, 0, "asym_r3f1"};
    vecs[3] = '{0, 0, 0, 0, 6, 16, 0, "start_mid_wait"};
    vecs[4] = '{0, 1, 0, 0, 0, 2047, 1, "stuck0"};
    vecs[5] = '{0, 0, 0, 0, 0, 16, 0, "after_timeout"};
    vecs[6] = '{1, 0, 3, 1, 0, 8, 0, "small_asym"};
    vecs[7] = '{1, 2, 0, 0, 0, 63, 1, "small_stuck1"};
    vecs[8] = '{1, 0, 0, 0, 0, 4, 0, "small_loopback"};

    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    din_model0 = 1'b0;
    din_model1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy0", 64'(busy0), 64'd0);
    checkOutput("reset done0", 64'(done0), 64'd0);
    checkOutput("reset timeout0", 64'(tmo0), 64'd0);
    checkOutput("reset result0", 64'(res0), 64'd0);
    checkOutput("reset chain_din0", 64'(din0), 64'd0);
    checkOutput("reset busy1", 64'(busy1), 64'd0);
    checkOutput("reset result1", 64'(res1), 64'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].sel, vecs[v].mode, vecs[v].r, vecs[v].f, vecs[v].pulse_at,
                    vecs[v].exp_res, vecs[v].exp_tmo, vecs[v].name);
    end

    // start held high: back-to-back measurements with one idle cycle between.
    $display("[TB] held start");
    mode0 = 0; rise0 = 0; fall0 = 0;
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done0) got = 1'b1;
    end
    checkOutput("held first done_seen", 64'(got), 64'd1);
    checkOutput("held first result", 64'(res0), 64'd16);
    @(negedge clk);
    checkOutput("held idle gap busy", 64'(busy0), 64'd0);
    @(negedge clk);
    checkOutput("held restart busy", 64'(busy0), 64'd1);
    start0 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done0) got = 1'b1;
    end
    checkOutput("held second done_seen", 64'(got), 64'd1);
    checkOutput("held second result", 64'(res0), 64'd16);
    checkOutput("held second timeout", 64'(tmo0), 64'd0);
    @(negedge clk);
    checkOutput("held second busy_after", 64'(busy0), 64'd0);

    // Reset during the first WAIT cycle of lap 3 (busy cycle 19).
    $display("[TB] reset mid-wait");
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    busy_cnt = 1;
    for (int i = 0; i < 100 && busy_cnt < 19; i++) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
    end
    checkOutput("rst reached lap3 wait", 64'(busy_cnt), 64'd19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din_model0 = 1'b0;
    din_model1 = 1'b0;
    checkOutput("rst busy", 64'(busy0), 64'd0);
    checkOutput("rst chain_din", 64'(din0), 64'd0);
    checkOutput("rst result", 64'(res0), 64'd0);
    checkOutput("rst timeout", 64'(tmo0), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (done0) done_cnt++;
    end
    checkOutput("rst no done pulse", 64'(done_cnt), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 16, 0, "post_rst_loopback");

    // Random chain delays (occasionally a stuck chain) against the model.
    $display("[TB] random measurements");
    for (int k = 0; k < 12; k++) begin
      int m;
      m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(k % 3 == 2 ? 1 : 0, m, int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)), 0, -1, -1, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
